// File: rtl/img_pkg.sv
// Shared types and constants for the BMP pixel reader: FSM states, byte-lane
// indices within a pixel triplet, and BMP row geometry helpers.
package img_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] IDX_B = 2'd0;
    localparam logic [1:0] IDX_G = 2'd1;
    localparam logic [1:0] IDX_R = 2'd2;

    localparam int HDR_BYTES_DEF = 54;

    // BMP rows are padded up to a multiple of 4 bytes.
    function automatic int row_stride(input int width);
        return ((3 * width + 3) / 4) * 4;
    endfunction

    function automatic int pad_bytes(input int width);
        return row_stride(width) - 3 * width;
    endfunction

endpackage

// File: rtl/bmp_addr_gen.sv
// Byte/column/row walker over the BMP pixel array. It produces the RAM byte
// address, jumps over row padding, and flags the final byte of the frame.
module bmp_addr_gen
    import img_pkg::*;
#(
    parameter int WIDTH     = 256,
    parameter int HEIGHT    = 256,
    parameter int HDR_BYTES = HDR_BYTES_DEF,
    parameter int ADDR_W    = 18
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic [1:0]        o_idx,
    output logic              o_last
);

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ADDR_HDR = ADDR_W'(HDR_BYTES);
    localparam logic [ADDR_W-1:0] ROW_JMP  = ADDR_W'(1 + pad_bytes(WIDTH));

    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_idx;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic              w_col_end;
    logic              w_row_end;

    assign w_col_end = (r_col == COL_LAST);
    assign w_row_end = (r_row == ROW_LAST);

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            r_addr <= '0;
            r_idx  <= IDX_B;
            r_col  <= '0;
            r_row  <= '0;
        end else if (i_load) begin
            r_addr <= ADDR_HDR;
            r_idx  <= IDX_B;
            r_col  <= '0;
            r_row  <= '0;
        end else if (i_step) begin
            if (r_idx == IDX_R) begin
                r_idx  <= IDX_B;
                // Padding is skipped within the same step, so no bubble appears.
                r_addr <= r_addr + (w_col_end ? ROW_JMP : ADDR_W'(1));
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end else begin
                r_idx  <= r_idx + 2'd1;
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    assign o_addr = r_addr;
    assign o_idx  = r_idx;
    assign o_last = (r_idx == IDX_R) && w_col_end && w_row_end;

endmodule

// File: rtl/bmp_pixel_reader.sv
// Streams 24-bit BMP pixels out of a byte-wide, 1-cycle-latency RAM as
// R/G/B bytes with a one-cycle OKout strobe, one pixel every 3 clocks.
module bmp_pixel_reader
    import img_pkg::*;
#(
    parameter int WIDTH     = 256,
    parameter int HEIGHT    = 256,
    parameter int HDR_BYTES = HDR_BYTES_DEF,
    parameter int ADDR_W    = 18
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [7:0]        mem_data,
    output logic [7:0]        Rout,
    output logic [7:0]        Gout,
    output logic [7:0]        Bout,
    output logic              OKout,
    output logic              busy,
    output logic              done
);

    state_t     r_state;
    state_t     w_next;
    logic       r_done;
    logic       r_dv;
    logic [1:0] r_didx;
    logic [7:0] r_b;
    logic [7:0] r_g;
    logic [7:0] r_rout;
    logic [7:0] r_gout;
    logic [7:0] r_bout;
    logic       r_ok;
    logic       w_load;
    logic       w_fetch;
    logic       w_last;
    logic       w_cap_r;
    logic [1:0] w_idx;

    assign w_load  = (r_state == IDLE) && start;
    assign w_fetch = (r_state == FETCH);
    assign w_cap_r = r_dv && (r_didx == IDX_R);

    bmp_addr_gen #(
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .HDR_BYTES (HDR_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_addr_gen (
        .clka   (clka),
        .reset  (reset),
        .i_load (w_load),
        .i_step (w_fetch),
        .o_addr (mem_addr),
        .o_idx  (w_idx),
        .o_last (w_last)
    );

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load)
                r_done <= 1'b0;
            else if ((r_state == DRAIN) && w_cap_r)
                r_done <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)   w_next = FETCH;
            FETCH:   if (w_last)  w_next = DRAIN;
            DRAIN:   if (w_cap_r) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // RAM data lags the request by one cycle, so the lane index rides along.
    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            r_dv   <= 1'b0;
            r_didx <= IDX_B;
            r_b    <= '0;
            r_g    <= '0;
            r_rout <= '0;
            r_gout <= '0;
            r_bout <= '0;
            r_ok   <= 1'b0;
        end else begin
            r_dv   <= w_fetch;
            r_didx <= w_idx;
            r_ok   <= w_cap_r;
            if (r_dv) begin
                case (r_didx)
                    IDX_B: r_b <= mem_data;
                    IDX_G: r_g <= mem_data;
                    IDX_R: begin
                        r_rout <= mem_data;
                        r_gout <= r_g;
                        r_bout <= r_b;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_en = w_fetch;
    assign busy   = (r_state != IDLE);
    assign done   = r_done;
    assign Rout   = r_rout;
    assign Gout   = r_gout;
    assign Bout   = r_bout;
    assign OKout  = r_ok;

endmodule

// File: tb/tb_bmp_pixel_reader.sv
// Directed bench: a 2x2 frame (with row padding) and a 4x1 frame (no padding)
// against behavioural 1-cycle-latency RAMs, with hand-computed expectations.
module tb_bmp_pixel_reader;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic        reset;
    logic        start_a, start_b;
    logic [17:0] addr_a, addr_b;
    logic        en_a, en_b;
    logic [7:0]  md_a, md_b;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        ok_a, ok_b, busy_a, busy_b, done_a, done_b;

    bmp_pixel_reader #(.WIDTH(2), .HEIGHT(2), .HDR_BYTES(54), .ADDR_W(18)) dut_a (
        .clka(clka), .reset(reset), .start(start_a),
        .mem_addr(addr_a), .mem_en(en_a), .mem_data(md_a),
        .Rout(r_a), .Gout(g_a), .Bout(b_a),
        .OKout(ok_a), .busy(busy_a), .done(done_a)
    );

    bmp_pixel_reader #(.WIDTH(4), .HEIGHT(1), .HDR_BYTES(54), .ADDR_W(18)) dut_b (
        .clka(clka), .reset(reset), .start(start_b),
        .mem_addr(addr_b), .mem_en(en_b), .mem_data(md_b),
        .Rout(r_b), .Gout(g_b), .Bout(b_b),
        .OKout(ok_b), .busy(busy_b), .done(done_b)
    );

    logic [7:0] mem_a [0:255];
    logic [7:0] mem_b [0:255];

    always @(posedge clka) if (en_a) md_a <= mem_a[addr_a[7:0]];
    always @(posedge clka) if (en_b) md_b <= mem_b[addr_b[7:0]];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    int q_addr[$];
    int q_pix[$];
    int q_okc[$];
    int done_cyc;
    logic done_k0;

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Start a frame on the selected DUT; k counts edges after the start edge.
    task automatic run(input bit sel, input int pulse_at);
        q_addr.delete(); q_pix.delete(); q_okc.delete();
        done_cyc = -1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clka); #1;
        start_a = 1'b0; start_b = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (sel) start_b = (k == pulse_at); else start_a = (k == pulse_at);
            if (k == 0) done_k0 = sel ? done_b : done_a;
            if (sel ? en_b : en_a) q_addr.push_back(int'(sel ? addr_b : addr_a));
            if (sel ? ok_b : ok_a) begin
                q_pix.push_back(sel ? int'({r_b, g_b, b_b}) : int'({r_a, g_a, b_a}));
                q_okc.push_back(k);
            end
            if ((sel ? done_b : done_a) && !(sel ? busy_b : busy_a)) begin
                done_cyc = k;
                break;
            end
            @(posedge clka); #1;
        end
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic quiet(input bit sel, input int ncyc, output int oks);
        oks = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clka); #1;
            if (sel ? ok_b : ok_a) oks++;
        end
    endtask

    int ea_a[12] = '{54, 55, 56, 57, 58, 59, 62, 63, 64, 65, 66, 67};
    int ep_a[4]  = '{32'h030201, 32'h060504, 32'h131211, 32'h161514};
    int ep_b[4]  = '{32'h222120, 32'h252423, 32'h282726, 32'h2b2a29};
    int oks;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'hAA;
            mem_b[i] = 8'h55;
        end
        for (int i = 0; i < 6; i++) begin
            mem_a[54 + i] = 8'(8'h01 + i);
            mem_a[62 + i] = 8'(8'h11 + i);
        end
        for (int i = 0; i < 12; i++) mem_b[54 + i] = 8'(8'h20 + i);

        reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
        #1;
        check("rst_out", {r_a, g_a, b_a, 7'd0, ok_a}, 32'h0);
        check("rst_ctl", {en_a, busy_a, done_a}, 3'b000);
        check("rst_addr", 32'(addr_a), 32'd0);
        @(posedge clka); @(posedge clka); #1;
        reset = 1'b1;
        @(posedge clka); #1;

        // 2x2 frame with 2 pad bytes per row
        run(1'b0, -1);
        check("a_naddr", q_addr.size(), 12);
        for (int i = 0; i < 12; i++) check($sformatf("a_addr%0d", i), qget(q_addr, i), ea_a[i]);
        check("a_npix", q_pix.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("a_pix%0d", i), qget(q_pix, i), ep_a[i]);
            check($sformatf("a_okc%0d", i), qget(q_okc, i), 4 + 3 * i);
        end
        check("a_done_cyc", done_cyc, 13);
        quiet(1'b0, 6, oks);
        check("a_no_extra_ok", oks, 0);
        check("a_done_hold", done_a, 1'b1);
        check("a_hold_rgb", {r_a, g_a, b_a}, 24'h161514);

        // 4x1 frame, no padding
        run(1'b1, -1);
        check("b_naddr", q_addr.size(), 12);
        for (int i = 0; i < 12; i++) check($sformatf("b_addr%0d", i), qget(q_addr, i), 54 + i);
        check("b_npix", q_pix.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("b_pix%0d", i), qget(q_pix, i), ep_b[i]);
        check("b_done_cyc", done_cyc, 13);

        // start pulsed mid-frame is ignored; restart after done clears done
        run(1'b0, 5);
        check("c_done_cleared", done_k0, 1'b0);
        check("c_naddr", q_addr.size(), 12);
        check("c_addr0", qget(q_addr, 0), 54);
        check("c_addr11", qget(q_addr, 11), 67);
        check("c_npix", q_pix.size(), 4);
        check("c_pix3", qget(q_pix, 3), ep_a[3]);
        check("c_done_cyc", done_cyc, 13);

        // asynchronous reset after the second pixel
        start_a = 1'b1;
        @(posedge clka); #1;
        start_a = 1'b0;
        oks = 0;
        for (int k = 0; k < 40 && oks < 2; k++) begin
            if (ok_a) oks++;
            if (oks < 2) begin @(posedge clka); #1; end
        end
        check("d_two_px", oks, 2);
        reset = 1'b0;
        #1;
        check("d_rst_out", {r_a, g_a, b_a, 7'd0, ok_a}, 32'h0);
        check("d_rst_ctl", {en_a, busy_a, done_a}, 3'b000);
        check("d_rst_addr", 32'(addr_a), 32'd0);
        quiet(1'b0, 6, oks);
        check("d_no_ok_in_rst", oks, 0);
        reset = 1'b1;
        quiet(1'b0, 4, oks);
        check("d_no_resume", {busy_a, 7'd0, 8'(oks)}, 16'h0);
        run(1'b0, -1);
        check("d_addr0", qget(q_addr, 0), 54);
        check("d_npix", q_pix.size(), 4);
        check("d_pix0", qget(q_pix, 0), ep_a[0]);
        check("d_done_cyc", done_cyc, 13);

        // all-FF memory
        for (int i = 0; i < 256; i++) mem_a[i] = 8'hFF;
        run(1'b0, -1);
        check("e_npix", q_pix.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("e_pix%0d", i), qget(q_pix, i), 32'hFFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bmp_pixel_reader.md
Name: bmp_pixel_reader

Overview:
- Upstream feeder for the per-pixel colour-processing stage (brightness, grayscale, filters, threshold, inversion).
- Walks a 24-bit BMP image held in a byte-wide, 1-cycle-latency block RAM, skipping the header and the per-row padding.
- Reassembles the B,G,R byte triplets into one pixel and presents it as Rout/Gout/Bout with a one-cycle OKout strobe. These outputs connect directly to Rin/Gin/Bin/OKin of the processing stage.

Parameters:
- WIDTH, 256, image width in pixels (>=1)
- HEIGHT, 256, image height in pixels (>=1)
- HDR_BYTES, 54, byte offset of the first pixel byte
- ADDR_W, 18, memory address width; must cover HDR_BYTES + HEIGHT*ROW_STRIDE

Ports:
- clka  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin frame read; sampled in IDLE only
- mem_addr  out  ADDR_W  byte address to image RAM
- mem_en  out  1  read enable to image RAM
- mem_data  in  8  RAM read data, valid the cycle after mem_addr/mem_en are sampled
- Rout  out  8  red byte of current pixel
- Gout  out  8  green byte of current pixel
- Bout  out  8  blue byte of current pixel
- OKout  out  1  one-cycle pixel-valid strobe
- busy  out  1  frame read in progress
- done  out  1  frame completed; level

Behaviour:
- Clock and reset: one clock, clka. Reset is asynchronous and active-low (port reset).
- Reset values (reset=0, asynchronous): state=IDLE; mem_addr=0; mem_en=0; Rout=Gout=Bout=0; OKout=0; busy=0; done=0; all counters and capture pipeline cleared.
- Derived constants:
  - ROW_STRIDE = ((3*WIDTH+3)/4)*4
  - PAD = ROW_STRIDE - 3*WIDTH (range 0..3)
- States: IDLE, FETCH, DRAIN.
- IDLE, start=1 at edge E0:
  - state=FETCH, busy=1, done=0.
  - mem_addr=HDR_BYTES, mem_en=1, byte_idx=0, col=0, row=0.
- FETCH, each edge:
  - Advance byte_idx 0->1->2->0.
  - mem_addr+=1, except on the last byte (idx 2) of a row's last column: mem_addr+=1+PAD. This skips row padding; no idle cycle is inserted.
  - col increments on idx-2 bytes. row increments when col wraps from WIDTH-1.
  - After the idx-2 byte of pixel (WIDTH-1,HEIGHT-1) is issued: mem_en=0, state=DRAIN.
- Capture pipeline:
  - Registered copy of (mem_en, byte_idx) delayed one cycle.
  - On each edge where the delayed enable is 1, mem_data is latched into b_reg/g_reg/r_reg for delayed idx 0/1/2.
  - On the edge capturing idx 2: Rout=mem_data, Gout=g_reg, Bout=b_reg, OKout=1. Otherwise OKout=0.
- Timing:
  - First OKout is set at edge E4.
  - Subsequent OKout strobes every 3 cycles.
  - Throughput is 1 pixel per 3 clocks.
  - Rout/Gout/Bout hold their value between strobes.
- DRAIN: on the edge that sets the final OKout, state=IDLE, busy=0, done=1. done stays 1 until the next accepted start.
- Pixel order is memory order: bottom BMP row first, left to right. No reordering.
- Half-cycle margin: outputs change only on rising edges. The downstream stage samples on the falling edge, so data and OKout are stable there.
- start while busy: ignored, with no restart and no effect on counters.
- start held high in IDLE after done: a new frame begins on that edge.
- Reset mid-frame: immediate abort to reset values. No partial pixel is emitted, and there is no resume.
- Width rules:
  - Address arithmetic is unsigned, ADDR_W bits, with no wrap within a legal parameter set.
  - col and row counters are sized by $clog2 of WIDTH and HEIGHT.

Decomposition:
- Shared package img_pkg holds:
  - state enum (IDLE/FETCH/DRAIN)
  - byte-index constants IDX_B=0, IDX_G=1, IDX_R=2
  - HDR_BYTES default
  - ROW_STRIDE/PAD constant functions
- One natural sub-module, bmp_addr_gen: byte_idx/col/row counters plus padding-aware mem_addr and last-byte flag. The top level holds the FSM and the capture pipeline.

Test Plan:
- WIDTH=2, HEIGHT=2, pixel bytes at 54..59 and 62..67 = 01..06 and 11..16, pulse start -> addresses 54,55,56,57,58,59,62,63,64,65,66,67 on consecutive cycles (pad 60,61 never addressed). OKout pixels (R,G,B) = (03,02,01), (06,05,04), (13,12,11), (16,15,14).
- Same setup -> first OKout at 4th edge after start edge; strobes exactly 3 cycles apart; busy falls and done rises on the edge of the 4th OKout.
- WIDTH=4 (PAD=0), HEIGHT=1 -> 12 contiguous addresses 54..65, 4 OKout strobes, no address jump.
- start pulsed again during FETCH -> address sequence and pixel count unchanged; a new start after done -> addresses restart at 54, done falls.
- reset driven low after the 2nd OKout -> all outputs 0 immediately; no further OKout; after reset release and start -> full frame from address 54.
- Memory returning FF for all bytes -> every pixel (FF,FF,FF), OKout count = WIDTH*HEIGHT exactly.
